// File: rtl/turf_scorer.sv
`default_nettype none
// =============================================================================
// Module   : turf_scorer
// Brief    : Scans the shared game RAM and counts the pixels owned by each of
//            four players, then reports the player holding the most turf.
// Revision : 1.0 - initial release
// =============================================================================
module turf_scorer #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        start,
  output logic [14:0] rd_address,
  input  logic [2:0]  rd_q,
  output logic        busy,
  output logic        done,
  output logic [14:0] score1,
  output logic [14:0] score2,
  output logic [14:0] score3,
  output logic [14:0] score4,
  output logic [2:0]  winner
);

  localparam logic [7:0] C_X_LAST = 8'(WIDTH - 1);
  localparam logic [6:0] C_Y_LAST = 7'(HEIGHT - 1);
  localparam bit         C_SINGLE = ((WIDTH * HEIGHT) == 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_DRAIN  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [7:0]  r_x;
  logic [6:0]  r_y;
  logic [7:0]  w_x_adv;
  logic [6:0]  w_y_adv;
  logic        w_adv_last;

  logic        r_vld1;
  logic        r_vld2;
  logic        r_drain_cnt;
  logic        r_busy;
  logic        r_done;
  logic [2:0]  r_winner;
  logic [14:0] r_score [4];

  logic        w_accept;
  logic        w_step;
  logic        w_finish;
  logic [2:0]  w_winner;
  logic [14:0] w_best;

  // Y runs fastest; X advances when Y wraps at the bottom row.
  always_comb begin
    w_x_adv = r_x;
    w_y_adv = r_y + 7'd1;
    if (r_y == C_Y_LAST) begin
      w_y_adv = 7'd0;
      w_x_adv = r_x + 8'd1;
    end
    w_adv_last = (w_x_adv == C_X_LAST) && (w_y_adv == C_Y_LAST);
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = C_SINGLE ? S_DRAIN : S_SCAN;
        end
      end
      S_SCAN: begin
        w_step = 1'b1;
        if (w_adv_last) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_drain_cnt) begin
          w_state_next = S_FINISH;
        end
      end
      S_FINISH: begin
        w_finish     = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_x         <= 8'd0;
      r_y         <= 7'd0;
      r_vld1      <= 1'b0;
      r_vld2      <= 1'b0;
      r_drain_cnt <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_winner    <= 3'd0;
    end else begin
      r_state     <= w_state_next;
      r_vld1      <= w_accept | w_step;
      r_vld2      <= r_vld1;
      r_done      <= w_finish;
      r_drain_cnt <= (r_state == S_DRAIN) ? ~r_drain_cnt : 1'b0;
      if (w_accept) begin
        r_x      <= 8'd0;
        r_y      <= 7'd0;
        r_busy   <= 1'b1;
        r_winner <= 3'd0;
      end else if (w_step) begin
        r_x <= w_x_adv;
        r_y <= w_y_adv;
      end
      if (w_finish) begin
        r_busy   <= 1'b0;
        r_winner <= w_winner;
      end
    end
  end

  // One counter per player; a sample is only trusted once its address has
  // travelled through both RAM latency stages.
  for (genvar p = 0; p < 4; p++) begin : g_player
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
        r_score[p] <= 15'd0;
      end else if (w_accept) begin
        r_score[p] <= 15'd0;
      end else if (r_vld2 && (rd_q == 3'(p + 1))) begin
        r_score[p] <= r_score[p] + 15'd1;
      end
    end
  end

  // Strict comparison keeps the lowest index on ties and yields 0 when empty.
  always_comb begin
    w_winner = 3'd0;
    w_best   = 15'd0;
    for (int p = 0; p < 4; p++) begin
      if (r_score[p] > w_best) begin
        w_best   = r_score[p];
        w_winner = 3'(p + 1);
      end
    end
  end

  assign rd_address = {r_x, r_y};
  assign busy       = r_busy;
  assign done       = r_done;
  assign winner     = r_winner;
  assign score1     = r_score[0];
  assign score2     = r_score[1];
  assign score3     = r_score[2];
  assign score4     = r_score[3];

endmodule
`default_nettype wire

// File: tb/tb_turf_scorer.sv
`default_nettype none
// =============================================================================
// Module   : tb_turf_scorer
// Brief    : Self-checking bench for turf_scorer on a reduced 40x30 field.
// Revision : 1.0 - initial release
// =============================================================================
module tb_turf_scorer;

  localparam int W = 40;
  localparam int H = 30;
  localparam int N = W * H;

  logic        CLOCK_50 = 1'b0;
  logic        resetn;
  logic        start;
  logic [14:0] rd_address;
  logic [2:0]  rd_q;
  logic        busy;
  logic        done;
  logic [14:0] score1;
  logic [14:0] score2;
  logic [14:0] score3;
  logic [14:0] score4;
  logic [2:0]  winner;

  logic [2:0]  mem [32768];

  int          errors = 0;
  int          checks = 0;
  int          exp_s [5];
  int          exp_w;
  int          mon_idx;
  int          mon_i;
  logic [14:0] mon_hold;
  logic        prev_busy;
  int          done_cnt;

  always #5 CLOCK_50 = ~CLOCK_50;

  turf_scorer #(.WIDTH(W), .HEIGHT(H)) dut (
    .CLOCK_50  (CLOCK_50),
    .resetn    (resetn),
    .start     (start),
    .rd_address(rd_address),
    .rd_q      (rd_q),
    .busy      (busy),
    .done      (done),
    .score1    (score1),
    .score2    (score2),
    .score3    (score3),
    .score4    (score4),
    .winner    (winner)
  );

  // Synchronous RAM output register: data for the address registered at
  // edge k is captured at k+1 and presented to the scorer for edge k+2.
  always @(posedge CLOCK_50) rd_q <= mem[rd_address];

  function automatic logic [14:0] addr_xy(input int x, input int y);
    return {8'(x), 7'(y)};
  endfunction

  function automatic logic [14:0] addr_of(input int i);
    return addr_xy(i / H, i % H);
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  task automatic compute_expected();
    int c;
    for (int k = 0; k < 5; k++) exp_s[k] = 0;
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++) begin
        c = int'(mem[addr_xy(x, y)]);
        if (c >= 1 && c <= 4) exp_s[c]++;
      end
    exp_w = 0;
    for (int k = 1; k <= 4; k++)
      if (exp_s[k] > exp_s[exp_w] || (exp_w == 0 && exp_s[k] > 0)) exp_w = k;
  endtask

  task automatic fill_const(input logic [2:0] v);
    for (int i = 0; i < 32768; i++) mem[i] = v;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 32768; i++) mem[i] = 3'($urandom_range(0, 7));
  endtask

  // Address sequence, IDLE hold, and done/busy relationship on every cycle.
  always @(negedge CLOCK_50) begin
    if (!resetn) begin
      prev_busy = 1'b0;
      mon_hold  = 15'd0;
    end else begin
      if (busy && !prev_busy) mon_idx = 0;
      if (busy) begin
        mon_i = (mon_idx < N) ? mon_idx : N - 1;
        chk("addr_seq", int'(rd_address), int'(addr_of(mon_i)));
        mon_hold = addr_of(mon_i);
        mon_idx++;
      end else begin
        chk("addr_hold", int'(rd_address), int'(mon_hold));
      end
      if (done) begin
        done_cnt++;
        chk("done_busy_low", int'(busy), 0);
      end
      prev_busy = busy;
    end
  end

  // One scan; start is accepted at the next rising edge. With keep_start the
  // task returns on the done cycle with start still high so the next scan
  // chains straight on. poke_at re-asserts start that many cycles in.
  task automatic run_scan(input string tag, input bit keep_start, input int poke_at);
    int t;
    if (!start) begin
      @(negedge CLOCK_50);
      start = 1'b1;
    end
    @(posedge CLOCK_50);
    #1;
    if (!keep_start) start = 1'b0;
    compute_expected();
    done_cnt = 0;
    for (t = 0; t < N + 50; t++) begin
      @(negedge CLOCK_50);
      if (!keep_start) start = (t == poke_at);
      if (done) break;
    end
    chk({tag, "_latency"}, t, N + 2);
    chk({tag, "_s1"}, int'(score1), exp_s[1]);
    chk({tag, "_s2"}, int'(score2), exp_s[2]);
    chk({tag, "_s3"}, int'(score3), exp_s[3]);
    chk({tag, "_s4"}, int'(score4), exp_s[4]);
    chk({tag, "_winner"}, int'(winner), exp_w);
    if (!keep_start) begin
      start = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      chk({tag, "_done_once"}, done_cnt, 1);
      chk({tag, "_idle_busy"}, int'(busy), 0);
      chk({tag, "_hold_s1"}, int'(score1), exp_s[1]);
      chk({tag, "_hold_winner"}, int'(winner), exp_w);
    end
  endtask

  initial begin
    resetn   = 1'b0;
    start    = 1'b0;
    mon_idx  = 0;
    mon_hold = 15'd0;
    done_cnt = 0;
    fill_const(3'd0);
    repeat (3) @(negedge CLOCK_50);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_addr", int'(rd_address), 0);
    chk("rst_s1", int'(score1), 0);
    chk("rst_winner", int'(winner), 0);
    resetn = 1'b1;
    repeat (2) @(negedge CLOCK_50);

    // Empty field.
    run_scan("zero", 1'b0, -1);
    chk("zero_winner_lit", int'(winner), 0);

    // Four equal quadrants: four-way tie resolves to player 1.
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++)
        mem[addr_xy(x, y)] = (y < H / 2) ? ((x < W / 2) ? 3'd1 : 3'd2)
                                         : ((x < W / 2) ? 3'd3 : 3'd4);
    run_scan("quad", 1'b0, -1);
    chk("quad_s1_lit", int'(score1), 300);
    chk("quad_s4_lit", int'(score4), 300);
    chk("quad_winner_lit", int'(winner), 1);

    // Last in-range pixel only; the column just past the edge must be unseen.
    fill_const(3'd0);
    mem[addr_xy(W - 1, H - 1)] = 3'd3;
    mem[addr_xy(W, 0)]         = 3'd2;
    run_scan("corner", 1'b0, -1);
    chk("corner_s3_lit", int'(score3), 1);
    chk("corner_s2_lit", int'(score2), 0);
    chk("corner_winner_lit", int'(winner), 3);

    // Ignored colour everywhere except ten player-4 pixels.
    begin
      int placed;
      logic [14:0] a;
      fill_const(3'd6);
      placed = 0;
      while (placed < 10) begin
        a = addr_xy($urandom_range(0, W - 1), $urandom_range(0, H - 1));
        if (mem[a] != 3'd4) begin
          mem[a] = 3'd4;
          placed++;
        end
      end
    end
    run_scan("ign", 1'b0, -1);
    chk("ign_s4_lit", int'(score4), 10);
    chk("ign_s1_lit", int'(score1), 0);
    chk("ign_winner_lit", int'(winner), 4);

    // Start re-pulsed mid-scan has no effect.
    fill_random();
    run_scan("poke", 1'b0, 100);

    // Reset halfway through a scan.
    fill_random();
    @(negedge CLOCK_50);
    start = 1'b1;
    @(posedge CLOCK_50);
    #1;
    start = 1'b0;
    repeat (N / 2) @(negedge CLOCK_50);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_addr", int'(rd_address), 0);
    chk("arst_s1", int'(score1), 0);
    chk("arst_s2", int'(score2), 0);
    chk("arst_s3", int'(score3), 0);
    chk("arst_s4", int'(score4), 0);
    chk("arst_winner", int'(winner), 0);
    done_cnt = 0;
    repeat (3) @(negedge CLOCK_50);
    resetn = 1'b1;
    repeat (N) @(negedge CLOCK_50);
    chk("arst_no_done", done_cnt, 0);
    chk("arst_idle_busy", int'(busy), 0);

    // Three back-to-back scans with start held high and fresh random data.
    for (int s = 0; s < 3; s++) begin
      fill_random();
      run_scan($sformatf("rand%0d", s), 1'b1, -1);
    end
    start = 1'b0;
    repeat (4) @(negedge CLOCK_50);
    chk("final_idle_busy", int'(busy), 0);
    chk("final_winner_hold", int'(winner), exp_w);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
